// File: rtl/matrix_inst_sequencer_pkg.sv
// Shared constants for the 2x2 matrix processor feeder: FSM encodings,
// one-hot opcodes, instruction field positions and the timeout result word.
package matrix_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM  = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_WRITE     = 3'd5;
  localparam logic [2:0] ST_FIN       = 3'd6;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_TRAN = 5'b01000;
  localparam logic [4:0] OP_DET  = 5'b10000;

  localparam int unsigned OP_MSB = 60;
  localparam int unsigned OP_LSB = 56;
  localparam int unsigned LANE_W = 7;
  localparam int unsigned A_LSB  = 0;
  localparam int unsigned B_LSB  = 28;

  localparam logic [31:0] ERR_WORD_DEF = 32'hFFFF_FFFF;

  function automatic logic [4:0] opcode_of(input logic [63:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/matrix_inst_sequencer_if.sv
// Memory and processor handshake bundle between the sequencer (master)
// and the instruction memory, processor and result memory (slave).
interface matrix_inst_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              im_rd;
  logic [ADDR_W-1:0] im_addr;
  logic [63:0]       im_rdata;
  logic              inst_valid;
  logic [63:0]       p_rdata;
  logic              done;
  logic [31:0]       p_wdata;
  logic              rm_we;
  logic [ADDR_W-1:0] rm_addr;
  logic [31:0]       rm_wdata;

  modport master (
    output im_rd, im_addr, inst_valid, p_rdata, rm_we, rm_addr, rm_wdata,
    input  im_rdata, done, p_wdata
  );

  modport slave (
    input  im_rd, im_addr, inst_valid, p_rdata, rm_we, rm_addr, rm_wdata,
    output im_rdata, done, p_wdata
  );
endinterface

// File: rtl/matrix_inst_sequencer_seq_watchdog.sv
// Per-instruction watchdog: cleared on issue, counts while waiting for done,
// expires on the TIMEOUT_CYC-th waiting cycle.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned W = $clog2(TIMEOUT_CYC) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (enable && !expire)  cnt <= cnt + W'(1);
  end

  assign expire = enable && (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/matrix_inst_sequencer.sv
// Walks instruction memory, issues each word to the matrix processor and
// stores its result; build option PERF_CNT_EN enables the busy-cycle counter.
module matrix_inst_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_WORD    = ERR_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     inst_count,
  output logic                  busy,
  output logic                  finish,
  output logic [7:0]            err_cnt,
  output logic [31:0]           cycle_cnt,
  matrix_inst_sequencer_if.master bus
);
  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] count, idx, last_idx;
  logic              wd_expire;
  logic              im_rd_q, inst_valid_q, rm_we_q;
  logic [63:0]       p_rdata_q;
  logic [31:0]       rm_wdata_q;

  assign last_idx = count - ADDR_W'(1);

  seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT_DONE),
    .expire (wd_expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = (inst_count == '0) ? ST_FIN : ST_FETCH;
      ST_FETCH:     state_nxt = ST_WAIT_MEM;
      ST_WAIT_MEM:  state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.done || wd_expire) state_nxt = ST_WRITE;
      ST_WRITE:     state_nxt = (idx == last_idx) ? ST_FIN : ST_FETCH;
      ST_FIN:       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are high in the
  // cycle the FSM sits in that state; finish fires on leaving FIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      finish       <= 1'b0;
      err_cnt      <= '0;
      im_rd_q      <= 1'b0;
      inst_valid_q <= 1'b0;
      rm_we_q      <= 1'b0;
      p_rdata_q    <= '0;
      rm_wdata_q   <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != ST_IDLE);
      finish       <= (state == ST_FIN);
      im_rd_q      <= (state_nxt == ST_FETCH);
      inst_valid_q <= (state_nxt == ST_ISSUE);
      rm_we_q      <= (state_nxt == ST_WRITE);
      case (state)
        ST_IDLE: if (start) begin
          count   <= inst_count;
          idx     <= '0;
          err_cnt <= '0;
        end
        ST_WAIT_MEM: p_rdata_q <= bus.im_rdata;
        ST_WAIT_DONE: begin
          if (bus.done) begin
            rm_wdata_q <= bus.p_wdata;
          end else if (wd_expire) begin
            rm_wdata_q <= ERR_WORD;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        ST_WRITE: if (idx != last_idx) idx <= idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.im_rd      = im_rd_q;
  assign bus.im_addr    = idx;
  assign bus.inst_valid = inst_valid_q;
  assign bus.p_rdata    = p_rdata_q;
  assign bus.rm_we      = rm_we_q;
  assign bus.rm_addr    = idx;
  assign bus.rm_wdata   = rm_wdata_q;

`ifdef PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            perf_q <= '0;
    else if (state == ST_IDLE && start)  perf_q <= '0;
    else if (busy)                       perf_q <= perf_q + 32'd1;
  end
  assign cycle_cnt = perf_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_matrix_inst_sequencer.sv
// Directed bench for matrix_inst_sequencer with memory/processor models and
// a write scoreboard.
module tb_matrix_inst_sequencer;
  import matrix_pkg::*;

  localparam int unsigned ADDR_W = 8;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] inst_count = '0;
  logic              busy, finish;
  logic [7:0]        err_cnt;
  logic [31:0]       cycle_cnt;

  matrix_inst_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  matrix_inst_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .inst_count (inst_count),
    .busy       (busy),
    .finish     (finish),
    .err_cnt    (err_cnt),
    .cycle_cnt  (cycle_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] imem [0:255];
  always @(posedge clk) if (bus.im_rd) bus.im_rdata <= imem[bus.im_addr];

  function automatic logic [31:0] proc_fn(input logic [63:0] w);
    logic [6:0]  a [4];
    logic [6:0]  b [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = w[7*i +: 7];
      b[i] = w[28 + 7*i +: 7];
    end
    case (w[60:56])
      OP_ADD:  for (int i = 0; i < 4; i++) r[7*i +: 7] = a[i] + b[i];
      OP_SUB:  for (int i = 0; i < 4; i++) r[7*i +: 7] = a[i] - b[i];
      OP_TRAN: begin
        r[6:0] = a[0]; r[13:7] = a[2]; r[20:14] = a[1]; r[27:21] = a[3];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Processor model: done four cycles after inst_valid, only for one-hot opcodes.
  logic [3:0] dly;
  always @(posedge clk or negedge rst) begin
    if (!rst) dly <= '0;
    else      dly <= {dly[2:0], bus.inst_valid && $onehot(bus.p_rdata[60:56])};
  end
  assign bus.done    = dly[3];
  assign bus.p_wdata = proc_fn(bus.p_rdata);

  function automatic logic [63:0] mk(input logic [4:0] op,
                                     input int unsigned a0, a1, a2, a3,
                                     input int unsigned b0, b1, b2, b3);
    logic [63:0] w;
    w = '0;
    w[60:56] = op;
    w[6:0]   = a0[6:0]; w[13:7]  = a1[6:0]; w[20:14] = a2[6:0]; w[27:21] = a3[6:0];
    w[34:28] = b0[6:0]; w[41:35] = b1[6:0]; w[48:42] = b2[6:0]; w[55:49] = b3[6:0];
    return w;
  endfunction

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int unsigned tests = 0;
  int unsigned fails = 0;

  int unsigned cyc, n_rd, n_iv, n_we;
  logic        prev_iv;
  logic        got_rd;
  logic [7:0]  first_rd_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.im_rd) begin
      if (!got_rd) begin
        got_rd = 1'b1;
        first_rd_addr = bus.im_addr;
      end
      n_rd++;
    end
    if (bus.inst_valid) begin
      n_iv++;
      chk("iv_width", prev_iv, 0);
      chk("p_rdata", bus.p_rdata, imem[bus.im_addr]);
    end
    prev_iv = bus.inst_valid;
    if (bus.rm_we) begin
      n_we++;
      chk("sb_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", bus.rm_addr, e.addr);
        chk("wr_data", bus.rm_wdata, e.data);
      end
    end
  endtask

  task automatic clr_obs();
    cyc = 0; n_rd = 0; n_iv = 0; n_we = 0;
    prev_iv = 1'b0; got_rd = 1'b0; first_rd_addr = '0;
  endtask

  task automatic run(input int unsigned n, input int unsigned exp_cyc, input string tag);
    clr_obs();
    @(negedge clk);
    inst_count = n[ADDR_W-1:0];
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    while (!finish && cyc < exp_cyc + 50) step();
    chk({tag, "_fin_seen"}, finish, 1);
    chk({tag, "_fin_cyc"}, cyc, exp_cyc);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_n_rd"}, n_rd, n);
    chk({tag, "_n_iv"}, n_iv, n);
    chk({tag, "_n_we"}, n_we, n);
    chk({tag, "_sb_empty"}, q.size(), 0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, PERF ? exp_cyc - 1 : 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {busy, finish, bus.im_rd, bus.inst_valid, bus.rm_we}, '0);
    chk({tag, "_err"}, err_cnt, '0);
    chk({tag, "_cc"}, cycle_cnt, '0);
    chk({tag, "_addr"}, {bus.im_addr, bus.rm_addr}, '0);
    chk({tag, "_prdata"}, bus.p_rdata, '0);
    chk({tag, "_wdata"}, bus.rm_wdata, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single ADD
    imem[0] = mk(OP_ADD, 1, 2, 3, 4, 5, 6, 7, 8);
    push(8'd0, 32'h0182_8406);
    run(1, 10, "single");
    chk("single_err", err_cnt, 0);
    chk("single_first_addr", first_rd_addr, 0);

    // ADD / SUB / TRAN program
    imem[0] = mk(OP_ADD, 10, 20, 30, 40, 1, 2, 3, 4);
    imem[1] = mk(OP_SUB, 50, 40, 30, 20, 5, 6, 7, 60);
    imem[2] = mk(OP_TRAN, 9, 8, 7, 6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(i[7:0], proc_fn(imem[i]));
    run(3, 2 + 3*8, "three");
    chk("three_err", err_cnt, 0);

    // Invalid opcode times out, run continues
    imem[0] = mk(5'b00011, 1, 1, 1, 1, 1, 1, 1, 1);
    imem[1] = mk(OP_ADD, 3, 3, 3, 3, 4, 4, 4, 4);
    push(8'd0, 32'hFFFF_FFFF);
    push(8'd1, proc_fn(imem[1]));
    run(2, 2 + 20 + 8, "timeout");
    chk("timeout_err", err_cnt, 1);

    // Empty run, also clears err_cnt
    run(0, 2, "empty");
    chk("empty_err", err_cnt, 0);

    // Two valid instructions; counter holds afterwards
    imem[0] = mk(OP_SUB, 7, 7, 7, 7, 1, 2, 3, 4);
    imem[1] = mk(OP_TRAN, 11, 22, 33, 44, 0, 0, 0, 0);
    push(8'd0, proc_fn(imem[0]));
    push(8'd1, proc_fn(imem[1]));
    run(2, 18, "two");
    chk("two_cc", cycle_cnt, PERF ? 17 : 0);
    repeat (5) @(negedge clk);
    chk("two_cc_hold", cycle_cnt, PERF ? 17 : 0);

    // Asynchronous reset during WAIT_DONE of the second instruction
    for (int i = 0; i < 3; i++) begin
      imem[i] = mk(OP_ADD, i, 1, 2, 3, 4, 5, 6, 7);
      push(i[7:0], proc_fn(imem[i]));
    end
    clr_obs();
    @(negedge clk);
    inst_count = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    while (n_iv < 2 && cyc < 100) step();
    chk("midrst_reach_iv2", n_iv, 2);
    step();
    chk("midrst_sb", q.size(), 2);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    imem[0] = mk(OP_SUB, 20, 20, 20, 20, 5, 5, 5, 5);
    push(8'd0, proc_fn(imem[0]));
    run(1, 10, "restart");
    chk("restart_first_addr", first_rd_addr, 0);

    // Maximum program length
    for (int i = 0; i < 255; i++) begin
      imem[i] = mk(OP_ADD, i, i + 1, 3, 100, 27, i, 0, i + 2);
      push(i[7:0], proc_fn(imem[i]));
    end
    run(255, 2 + 255*8, "max");
    chk("max_err", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
